// File: rtl/rvfi_mem_responder.sv
// rvfi_mem_responder: valid/ready memory responder with latency, bounded stalls, backing store,
// protocol checking and traffic counters.
module rvfi_mem_responder #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 1,
    parameter int MAX_STALL  = 3,
    parameter int RAND_MODE  = 0
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_mem_valid,
    input  logic                i_mem_instr,
    input  logic [31:0]         i_mem_addr,
    input  logic [DATA_W-1:0]   i_mem_wdata,
    input  logic [DATA_W/8-1:0] i_mem_wstrb,
    output logic                o_mem_ready,
    output logic [DATA_W-1:0]   o_mem_rdata,
    input  logic                i_stall_in,
    input  logic [DATA_W-1:0]   i_rand_rdata,
    output logic                o_proto_err,
    output logic [31:0]         o_ifetch_cnt,
    output logic [31:0]         o_data_cnt
);
    localparam int NB = DATA_W / 8;
    localparam int B = $clog2(NB);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
    localparam logic [7:0] MS = 8'(MAX_STALL);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [7:0]          r_stall;
    logic [31:0]         r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NB-1:0]       r_wstrb;
    logic                r_instr;
    logic                r_ready;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_proto;
    logic [31:0]         r_icnt;
    logic [31:0]         r_dcnt;
    logic [DATA_W-1:0]   r_mem [0:2**DEPTH_LOG2-1];

    logic                  w_go_resp;
    logic                  w_rwr;
    logic                  w_mism;
    logic [DEPTH_LOG2-1:0] w_ridx;
    logic [DEPTH_LOG2-1:0] w_widx;

    // With LATENCY=0 the response is decided in IDLE, before the request is captured.
    assign w_go_resp = (r_state == IDLE && i_mem_valid && LATENCY == 0) ||
                       (r_state == WAIT && !(i_stall_in && r_stall < MS) && r_cnt == 4'd0);
    assign w_ridx = r_state == IDLE ? i_mem_addr[DEPTH_LOG2+B-1:B] : r_addr[DEPTH_LOG2+B-1:B];
    assign w_rwr = r_state == IDLE ? |i_mem_wstrb : |r_wstrb;
    assign w_widx = r_addr[DEPTH_LOG2+B-1:B];
    assign w_mism = !i_mem_valid || i_mem_addr != r_addr || i_mem_wstrb != r_wstrb ||
                    i_mem_instr != r_instr || i_mem_wdata != r_wdata;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stall <= '0;
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_proto <= 1'b0;
            r_icnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            r_ready <= w_go_resp;
            r_rdata <= (w_go_resp && !w_rwr && RAND_MODE == 0) ? r_mem[w_ridx] : '0;
            if (r_state != IDLE && w_mism)
                r_proto <= 1'b1;
            case (r_state)
                IDLE: if (i_mem_valid) begin
                    r_addr  <= i_mem_addr;
                    r_wdata <= i_mem_wdata;
                    r_wstrb <= i_mem_wstrb;
                    r_instr <= i_mem_instr;
                    r_cnt   <= LAT_M1;
                    r_state <= LATENCY == 0 ? RESP : WAIT;
                end
                WAIT: if (i_stall_in && r_stall < MS)
                    r_stall <= r_stall + 8'd1;
                else if (r_cnt == 4'd0)
                    r_state <= RESP;
                else
                    r_cnt <= r_cnt - 4'd1;
                RESP: begin
                    r_state <= IDLE;
                    r_stall <= '0;
                    r_icnt  <= r_instr ? r_icnt + 32'd1 : r_icnt;
                    r_dcnt  <= r_instr ? r_dcnt : r_dcnt + 32'd1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store has no reset; a reset in RESP suppresses the commit.
    always_ff @(posedge i_clock) begin
        if (!i_reset && r_state == RESP)
            for (int b = 0; b < NB; b++)
                if (r_wstrb[b])
                    r_mem[w_widx][8*b +: 8] <= r_wdata[8*b +: 8];
    end

    assign o_mem_ready  = r_ready;
    assign o_mem_rdata  = (RAND_MODE != 0 && r_ready && !(|r_wstrb)) ? i_rand_rdata : r_rdata;
    assign o_proto_err  = r_proto;
    assign o_ifetch_cnt = r_icnt;
    assign o_data_cnt   = r_dcnt;
endmodule
